// File: rtl/dualmem_widen_sync_if.sv
// Bus bundle for dualmem_widen_sync: narrow port A, wide port B and the collision flag.
// The RAM side takes the slave modport.
interface dualmem_widen_sync_if #(
    parameter int unsigned WA      = 16,
    parameter int unsigned RATIO   = 4,
    parameter int unsigned DEPTH_B = 2048
);
    localparam int unsigned WB  = WA * RATIO;
    localparam int unsigned AWB = $clog2(DEPTH_B);
    localparam int unsigned AWA = AWB + $clog2(RATIO);
    localparam int unsigned BEA = WA / 8;
    localparam int unsigned BEB = WB / 8;

    logic           a_req_i;
    logic           a_we_i;
    logic [BEA-1:0] a_be_i;
    logic [AWA-1:0] a_addr_i;
    logic [WA-1:0]  a_wdata_i;
    logic [WA-1:0]  a_rdata_o;
    logic           a_rvalid_o;

    logic           b_req_i;
    logic           b_we_i;
    logic [BEB-1:0] b_be_i;
    logic [AWB-1:0] b_addr_i;
    logic [WB-1:0]  b_wdata_i;
    logic [WB-1:0]  b_rdata_o;
    logic           b_rvalid_o;

    logic           collision_o;

    modport master (
        output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
        input  a_rdata_o, a_rvalid_o,
        output b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
        input  b_rdata_o, b_rvalid_o,
        input  collision_o
    );

    modport slave (
        input  a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
        output a_rdata_o, a_rvalid_o,
        input  b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
        output b_rdata_o, b_rvalid_o,
        output collision_o
    );
endinterface

// File: rtl/dualmem_widen_sync.sv
// Single-clock asymmetric true-dual-port buffer: narrow port A, wide port B, read-first, B wins on
// overlapping same-cycle writes. Define DUALMEM_OREG_EN for an extra output register stage.
module dualmem_widen_sync #(
    parameter int unsigned WA      = 16,
    parameter int unsigned RATIO   = 4,
    parameter int unsigned DEPTH_B = 2048
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    dualmem_widen_sync_if.slave bus
);
    localparam int unsigned WB  = WA * RATIO;
    localparam int unsigned AWB = $clog2(DEPTH_B);
    localparam int unsigned LW  = $clog2(RATIO);
    localparam int unsigned AWA = AWB + LW;
    localparam int unsigned BEA = WA / 8;
    localparam int unsigned BEB = WB / 8;

    logic [WB-1:0] mem [DEPTH_B];

    logic [LW-1:0]  a_lane;
    logic [AWB-1:0] a_entry;
    logic           a_wr, a_rd, b_wr, b_rd;
    logic [BEB-1:0] a_be_word;
    logic [WB-1:0]  a_wdata_word;
    logic           collision_d;

    // Writes are gated by reset so requests presented while in reset are dropped.
    always_comb begin
        a_lane       = bus.a_addr_i[LW-1:0];
        a_entry      = bus.a_addr_i[AWA-1:LW];
        a_wr         = rst_ni & bus.a_req_i & bus.a_we_i;
        a_rd         = bus.a_req_i & ~bus.a_we_i;
        b_wr         = rst_ni & bus.b_req_i & bus.b_we_i;
        b_rd         = bus.b_req_i & ~bus.b_we_i;
        a_be_word    = BEB'(bus.a_be_i) << (a_lane * BEA);
        a_wdata_word = {RATIO{bus.a_wdata_i}};
        collision_d  = a_wr & b_wr & (a_entry == bus.b_addr_i)
                     & (|(a_be_word & bus.b_be_i));
    end

    // Port B updates are issued after port A so B takes the byte when both hit it.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < BEB; k++) begin
            if (a_wr && a_be_word[k]) mem[a_entry][k*8 +: 8] <= a_wdata_word[k*8 +: 8];
        end
        for (int k = 0; k < BEB; k++) begin
            if (b_wr && bus.b_be_i[k]) mem[bus.b_addr_i][k*8 +: 8] <= bus.b_wdata_i[k*8 +: 8];
        end
    end

    logic [WB-1:0] a_word_q;
    logic [LW-1:0] a_lane_q;
    logic          a_rvalid_q;
    logic [WB-1:0] b_rdata_q;
    logic          b_rvalid_q;
    logic          collision_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_word_q    <= '0;
            a_lane_q    <= '0;
            a_rvalid_q  <= 1'b0;
            b_rdata_q   <= '0;
            b_rvalid_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            a_rvalid_q  <= a_rd;
            b_rvalid_q  <= b_rd;
            collision_q <= collision_d;
            if (a_rd) begin
                a_word_q <= mem[a_entry];
                a_lane_q <= a_lane;
            end
            if (b_rd) begin
                b_rdata_q <= mem[bus.b_addr_i];
            end
        end
    end

    logic [WA-1:0] a_rdata_s1;
    assign a_rdata_s1 = a_word_q[a_lane_q * WA +: WA];

`ifdef DUALMEM_OREG_EN
    logic [WA-1:0] a_rdata_q2;
    logic          a_rvalid_q2;
    logic [WB-1:0] b_rdata_q2;
    logic          b_rvalid_q2;
    logic          collision_q2;

    // Second stage only loads on valid data so rdata keeps holding between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_q2   <= '0;
            a_rvalid_q2  <= 1'b0;
            b_rdata_q2   <= '0;
            b_rvalid_q2  <= 1'b0;
            collision_q2 <= 1'b0;
        end else begin
            a_rvalid_q2  <= a_rvalid_q;
            b_rvalid_q2  <= b_rvalid_q;
            collision_q2 <= collision_q;
            if (a_rvalid_q) a_rdata_q2 <= a_rdata_s1;
            if (b_rvalid_q) b_rdata_q2 <= b_rdata_q;
        end
    end

    assign bus.a_rdata_o   = a_rdata_q2;
    assign bus.a_rvalid_o  = a_rvalid_q2;
    assign bus.b_rdata_o   = b_rdata_q2;
    assign bus.b_rvalid_o  = b_rvalid_q2;
    assign bus.collision_o = collision_q2;
`else
    assign bus.a_rdata_o   = a_rdata_s1;
    assign bus.a_rvalid_o  = a_rvalid_q;
    assign bus.b_rdata_o   = b_rdata_q;
    assign bus.b_rvalid_o  = b_rvalid_q;
    assign bus.collision_o = collision_q;
`endif

endmodule
